pipe_reg_chain: RTL and testbench

//  Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline.

---
 rtl/pipe_reg_chain_if.sv | 21 ++
 rtl/pipe_reg_chain.sv | 75 +++++++
 tb/tb_pipe_reg_chain.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready word stream used on both sides of pipe_reg_chain.
// Master drives valid/data, slave drives ready.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage WIDTH-bit register pipeline with per-stage valid bits,
// valid/ready handshake and bubble collapse.
module pipe_reg_chain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              OW        = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    pipe_reg_chain_if.slave   s_in,
    pipe_reg_chain_if.master  m_out,
    output logic [OW-1:0]     o_occupancy
);

    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [OW-1:0]               r_occ;

    logic [DEPTH-1:0] w_adv;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_emit;

    // Walk from the output back: a stage may move if the slot ahead
    // is free or is itself moving this cycle.
    always_comb begin
        logic free;
        free  = m_out.ready;
        w_adv = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            w_adv[s] = r_v[s] & free;
            free     = ~r_v[s] | w_adv[s];
        end
        w_in_ready = free;
    end

    assign w_accept = s_in.valid & w_in_ready;
    assign w_emit   = w_adv[DEPTH-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v    <= '0;
            r_data <= {DEPTH{RESET_VAL}};
            r_occ  <= '0;
        end else if (i_clr) begin
            r_v    <= '0;
            r_data <= {DEPTH{RESET_VAL}};
            r_occ  <= '0;
        end else begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                if (w_adv[s-1]) begin
                    r_data[s] <= r_data[s-1];
                    r_v[s]    <= 1'b1;
                end else if (w_adv[s]) begin
                    r_v[s] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_data[0] <= s_in.data;
                r_v[0]    <= 1'b1;
            end else if (w_adv[0]) begin
                r_v[0] <= 1'b0;
            end
            r_occ <= r_occ + OW'(w_accept) - OW'(w_emit);
        end
    end

    assign s_in.ready   = w_in_ready;
    assign m_out.valid  = r_v[DEPTH-1];
    assign m_out.data   = r_data[DEPTH-1];
    assign o_occupancy  = r_occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain against a
// queue-of-words position model.
module tb_pipe_reg_chain;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic [OW-1:0] occ;

    pipe_reg_chain_if #(.WIDTH(W)) u_in  ();
    pipe_reg_chain_if #(.WIDTH(W)) u_out ();

    pipe_reg_chain #(
        .WIDTH    (W),
        .DEPTH    (D),
        .RESET_VAL(8'h00)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clr      (clr),
        .s_in       (u_in),
        .m_out      (u_out),
        .o_occupancy(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: words oldest-first with their stage index.
    int         m_pos[$];
    logic [7:0] m_val[$];
    logic [7:0] emitted[$];
    bit         saw_3c = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit m_out_valid();
        return m_pos.size() > 0 && m_pos[0] == D - 1;
    endfunction

    function automatic bit m_in_ready();
        return !(m_pos.size() == D && !u_out.ready);
    endfunction

    task automatic m_clear();
        m_pos.delete();
        m_val.delete();
    endtask

    // Called at a negedge with inputs already driven.
    task automatic cycle();
        bit acc;
        bit emit;
        int lim;
        #1;
        chk("in_ready", int'(u_in.ready), int'(m_in_ready()));
        chk("out_valid", int'(u_out.valid), int'(m_out_valid()));
        chk("occupancy", int'(occ), m_pos.size());
        if (m_out_valid())
            chk("q", int'(u_out.data), int'(m_val[0]));
        if (u_out.valid && u_out.data == 8'h3c)
            saw_3c = 1;
        acc  = u_in.valid && m_in_ready();
        emit = m_out_valid() && u_out.ready;
        if (clr) begin
            m_clear();
        end else begin
            if (emit) begin
                emitted.push_back(m_val[0]);
                void'(m_pos.pop_front());
                void'(m_val.pop_front());
            end
            for (int i = 0; i < m_pos.size(); i++) begin
                lim = (i == 0) ? D - 1 : m_pos[i-1] - 1;
                m_pos[i] = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
            end
            if (acc) begin
                m_pos.push_back(0);
                m_val.push_back(u_in.data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        u_in.valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [7:0] w;
        rst_n       = 1'b0;
        clr         = 1'b0;
        u_in.valid  = 1'b0;
        u_in.data   = 8'h00;
        u_out.ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(u_out.valid), 0);
        chk("rst_q", int'(u_out.data), 0);
        chk("rst_occ", int'(occ), 0);
        chk("rst_in_ready", int'(u_in.ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: accepted at edge 0, visible after edge 3 for one cycle.
        u_out.ready = 1'b1;
        u_in.valid  = 1'b1;
        u_in.data   = 8'ha5;
        cycle();
        u_in.valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("lat_valid_%0d", k), int'(u_out.valid),
                (k == 3) ? 1 : 0);
            if (k == 3)
                chk("lat_q", int'(u_out.data), 8'ha5);
            cycle();
        end

        // Streaming 0..19.
        emitted.delete();
        u_out.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            u_in.valid = 1'b1;
            u_in.data  = 8'(i);
            #1;
            chk("stream_in_ready", int'(u_in.ready), 1);
            cycle();
        end
        idle(6);
        chk("stream_count", emitted.size(), 20);
        for (int i = 0; i < emitted.size() && i < 20; i++)
            chk("stream_order", int'(emitted[i]), i);

        // Backpressure: feed 6 words, 4 fit.
        emitted.delete();
        u_out.ready = 1'b0;
        w = 8'h40;
        for (int i = 0; i < 8; i++) begin
            u_in.valid = 1'b1;
            u_in.data  = w;
            #1;
            if (u_in.ready) w++;
            cycle();
        end
        #1;
        chk("bp_in_ready", int'(u_in.ready), 0);
        chk("bp_occ", int'(occ), 4);
        chk("bp_q", int'(u_out.data), 8'h40);
        chk("bp_accepted", int'(w), 8'h44);
        u_out.ready = 1'b1;
        while (w < 8'h46) begin
            u_in.valid = 1'b1;
            u_in.data  = w;
            #1;
            if (u_in.ready) w++;
            cycle();
        end
        idle(8);
        chk("bp_drain_count", emitted.size(), 6);
        for (int i = 0; i < emitted.size() && i < 6; i++)
            chk("bp_drain_order", int'(emitted[i]), 8'h40 + i);

        // Bubble: word A reaches stage 3, then B enters stage 0.
        u_out.ready = 1'b0;
        u_in.valid  = 1'b1;
        u_in.data   = 8'h11;
        cycle();
        idle(3);
        u_in.valid = 1'b1;
        u_in.data  = 8'h22;
        cycle();
        u_in.valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bub_occ", int'(occ), 2);
            chk("bub_q", int'(u_out.data), 8'h11);
            cycle();
        end
        u_out.ready = 1'b1;
        idle(3);

        // CLR collides with accept and emit.
        u_out.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u_in.valid = 1'b1;
            u_in.data  = 8'h70 + 8'(i);
            cycle();
        end
        saw_3c      = 0;
        clr         = 1'b1;
        u_in.valid  = 1'b1;
        u_in.data   = 8'h3c;
        u_out.ready = 1'b1;
        #1;
        chk("clr_pre_out_valid", int'(u_out.valid), 1);
        cycle();
        clr        = 1'b0;
        u_in.valid = 1'b0;
        #1;
        chk("clr_occ", int'(occ), 0);
        chk("clr_out_valid", int'(u_out.valid), 0);
        idle(6);
        chk("clr_no_3c", int'(saw_3c), 0);

        // Async reset with 3 words in flight.
        u_out.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            u_in.valid = 1'b1;
            u_in.data  = 8'h90 + 8'(i);
            cycle();
        end
        u_in.valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", int'(u_out.valid), 0);
        chk("t1_q", int'(u_out.data), 0);
        chk("t1_occ", int'(occ), 0);
        chk("t1_in_ready", int'(u_in.ready), 1);
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            u_in.valid  = 1'($urandom_range(0, 99) < 70);
            u_in.data   = 8'($urandom);
            u_out.ready = 1'($urandom_range(0, 99) < 60);
            clr         = 1'($urandom_range(0, 99) < 3);
            cycle();
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
